// File: rtl/feed_cmd_tx.sv
// feed_cmd_tx -- serial command transmitter for the feeder controller link.
//
// Frames a 1-bit command with an 8-bit data byte and drives it onto one
// UART-style line, LSB first:
//   start(0), dado[0..7], comando, [even parity], stop(1)
//
// Optional feature: define FEED_CMD_TX_PARITY_EN to insert an even-parity bit
// after the comando bit (12-bit frame instead of 11).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
// Ports:
//   clock         system clock, rising edge
//   reset         synchronous active-low reset
//   partida       start request, sampled only in espera
//   comando       command bit, latched at accept
//   dado[7:0]     data byte, latched at accept
//   saida_serial  registered serial line, idles high
//   ocupado       high from accept through the pronto cycle
//   pronto        one-cycle pulse when a frame completes
//   db_estado     current FSM state (debug)
module feed_cmd_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       partida,
    input  logic       comando,
    input  logic [7:0] dado,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

`ifdef FEED_CMD_TX_PARITY_EN
    localparam int N_BITS = 12;
`else
    localparam int N_BITS = 11;
`endif
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        st_inicial     = 3'b000,
        st_espera      = 3'b001,
        st_transmissao = 3'b010,
        st_final       = 3'b011
    } state_t;

    state_t            state, next_state;
    logic [N_BITS-1:0] shreg;
    logic [N_BITS-1:0] frame;
    logic [TW-1:0]     tick;
    logic [3:0]        bitcnt;
    logic              tick_end;
    logic              last_bit;
    logic              accept;

    assign tick_end  = (tick == TW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bitcnt == 4'(N_BITS - 1));
    assign accept    = (state == st_espera) && partida;
    assign db_estado = state;

    // Shift register holds the frame with the first line bit at [0];
    // stop bit sits at the MSB and ones are shifted in behind it.
`ifdef FEED_CMD_TX_PARITY_EN
    assign frame = {1'b1, ^{comando, dado}, comando, dado, 1'b0};
`else
    assign frame = {1'b1, comando, dado, 1'b0};
`endif

    always_comb begin
        next_state = state;
        case (state)
            st_inicial:     next_state = st_espera;
            st_espera:      if (partida) next_state = st_transmissao;
            st_transmissao: if (tick_end && last_bit) next_state = st_final;
            st_final:       next_state = st_espera;
            default:        next_state = st_inicial;
        endcase
    end

    // Outputs are registered from the current state, so they trail the
    // state register by one cycle: the start bit appears the edge after
    // accept and pronto appears the edge after the last bit period ends.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= st_inicial;
            shreg        <= '1;
            tick         <= '0;
            bitcnt       <= '0;
            saida_serial <= 1'b1;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                shreg  <= frame;
                tick   <= '0;
                bitcnt <= '0;
            end else if (state == st_transmissao) begin
                if (tick_end) begin
                    tick   <= '0;
                    bitcnt <= bitcnt + 4'd1;
                    shreg  <= {1'b1, shreg[N_BITS-1:1]};
                end else begin
                    tick <= tick + 1'b1;
                end
            end
            saida_serial <= (state == st_transmissao) ? shreg[0] : 1'b1;
            ocupado      <= (state == st_transmissao) || (state == st_final);
            pronto       <= (state == st_final);
        end
    end

endmodule

// File: tb/tb_feed_cmd_tx.sv
module tb_feed_cmd_tx;
    localparam int C = 4;
`ifdef FEED_CMD_TX_PARITY_EN
    localparam int N = 12;
`else
    localparam int N = 11;
`endif
    localparam int NC = N * C;

    logic       clock = 1'b0;
    logic       reset;
    logic       partida;
    logic       comando;
    logic [7:0] dado;
    logic       saida_serial;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    feed_cmd_tx #(.CLKS_PER_BIT(C)) dut (
        .clock        (clock),
        .reset        (reset),
        .partida      (partida),
        .comando      (comando),
        .dado         (dado),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] bits;
        bit          b2b;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Expected line sequence, first bit at [0].
    function automatic logic [11:0] frame_of(input logic c, input logic [7:0] d);
`ifdef FEED_CMD_TX_PARITY_EN
        return {1'b1, ^{c, d}, c, d, 1'b0};
`else
        return {1'b0, 1'b1, c, d, 1'b0};
`endif
    endfunction

    // Monitor: a frame starts when ocupado rises; every bit must hold for
    // all C cycles, followed by one pronto cycle and then an idle cycle.
    int       cyc       = 0;
    int       gcyc      = 0;
    int       last_idle = -100;
    bit       in_frame  = 0;
    logic     prev_oc   = 1'b0;
    logic [3:0] samp;
    exp_t     cur;

    always @(negedge clock) begin
        gcyc++;
        if (!in_frame) begin
            if (pronto === 1'b1) chk("spurious_pronto", 32'(pronto), 32'd0);
            if (ocupado === 1'b1 && prev_oc !== 1'b1) begin
                if (sb.size() == 0) chk("unexpected_frame", 32'd1, 32'd0);
                else begin
                    cur      = sb.pop_front();
                    in_frame = 1;
                    cyc      = 0;
                    if (cur.b2b) chk("b2b_gap", 32'(gcyc - last_idle), 32'd1);
                end
            end
        end
        if (in_frame) begin
            if (cyc < NC) begin
                samp[cyc % C] = saida_serial;
                if (ocupado !== 1'b1 || pronto !== 1'b0)
                    chk($sformatf("busy_in_frame_c%0d", cyc), 32'({ocupado, pronto}), 32'b10);
                if (cyc % C == C - 1)
                    chk($sformatf("bit%0d", cyc / C), 32'(samp), 32'({4{cur.bits[cyc / C]}}));
            end else if (cyc == NC) begin
                chk("pronto_cycle", 32'({saida_serial, ocupado, pronto}), 32'b111);
            end else begin
                chk("after_pronto", 32'({saida_serial, ocupado, pronto}), 32'b100);
                in_frame  = 0;
                last_idle = gcyc;
            end
            cyc++;
            // reset sampled at the coming edge aborts the frame
            if (reset === 1'b0) in_frame = 0;
        end
        prev_oc = ocupado;
    end

    task automatic send(input logic c, input logic [7:0] d);
        exp_t e;
        @(posedge clock); #1;
        comando = c;
        dado    = d;
        partida = 1'b1;
        e.bits  = frame_of(c, d);
        e.b2b   = 0;
        sb.push_back(e);
        @(posedge clock); #1;
        partida = 1'b0;
    endtask

    initial begin
        exp_t e;
        reset   = 1'b0;
        partida = 1'b0;
        comando = 1'b0;
        dado    = 8'h00;

        // reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", 32'({saida_serial, ocupado, pronto}), 32'b100);
        chk("reset_estado", 32'(db_estado), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("estado_inicial", 32'(db_estado), 32'd0);
        @(negedge clock);
        chk("estado_espera", 32'(db_estado), 32'd1);

        // basic frame A5 / comando 1
        send(1'b1, 8'hA5);
        @(negedge clock);
        chk("estado_transmissao", 32'(db_estado), 32'd2);
        repeat (NC + 6) @(posedge clock);

        // partida and dado change mid-frame must not disturb it
        send(1'b0, 8'h3C);
        repeat (20) @(posedge clock);
        #1;
        dado    = 8'h00;
        partida = 1'b1;
        @(posedge clock); #1;
        partida = 1'b0;
        repeat (NC) @(posedge clock);
        @(negedge clock);
        chk("no_requeue", 32'(sb.size()), 32'd0);
        chk("idle_after_ignore", 32'(ocupado), 32'd0);

        // reset during data bit 3 aborts the frame
        send(1'b1, 8'hFF);
        repeat (17) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("abort_line_busy", 32'({saida_serial, ocupado, pronto}), 32'b100);
        @(posedge clock); #1;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        send(1'b0, 8'h5A);
        repeat (NC + 6) @(posedge clock);

        // partida held high: three back-to-back frames
        for (int i = 0; i < 3; i++) begin
            e.bits = frame_of(1'b0, 8'h01);
            e.b2b  = (i != 0);
            sb.push_back(e);
        end
        @(posedge clock); #1;
        comando = 1'b0;
        dado    = 8'h01;
        partida = 1'b1;
        @(posedge clock);
        repeat (2 * (NC + 2)) @(posedge clock);
        #1;
        partida = 1'b0;
        repeat (NC + 6) @(posedge clock);

        @(negedge clock);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'({saida_serial, ocupado, pronto}), 32'b100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
